// File: rtl/mux_5_1_scanner.sv
// mux_5_1_scanner: steps a 5:1 mux select over masked channels and publishes a sampled 5-bit snapshot
module mux_5_1_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] en_mask,
    output logic [2:0] sel,
    input  logic       mux_y,
    output logic       busy,
    output logic [4:0] snap,
    output logic       snap_valid,
    input  logic       snap_ready
);
    typedef enum logic [1:0] {IDLE, SETTLE, PUBLISH} state_t;
    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
    state_t     r_state, w_state_nxt;
    logic [4:0] r_mask, r_acc, r_snap, w_mask_nxt, w_acc_nxt, w_snap_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_sel, w_sel_nxt, w_first, w_next;
    logic       r_valid, w_valid_nxt, w_has_next, w_load;

    // r_sel doubles as the current channel while scanning; descending loop leaves the lowest candidate
    always_comb begin
        w_first    = 3'd0;
        w_next     = 3'd0;
        w_has_next = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            if (en_mask[k]) w_first = 3'(k);
            if (r_mask[k] && 3'(k) > r_sel) begin
                w_next     = 3'(k);
                w_has_next = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_mask_nxt  = r_mask;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            IDLE: if (start && |en_mask) begin
                w_state_nxt = SETTLE;
                w_mask_nxt  = en_mask;
                w_acc_nxt   = 5'd0;
                w_sel_nxt   = w_first;
                w_cnt_nxt   = LP_SETTLE;
            end
            SETTLE: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_acc_nxt[r_sel] = mux_y;
                    w_cnt_nxt        = LP_SETTLE;
                    w_sel_nxt        = w_has_next ? w_next : 3'd7;
                    w_state_nxt      = w_has_next ? SETTLE : PUBLISH;
                end
            end
            PUBLISH: if (!r_valid || snap_ready) begin
                w_load      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_snap_nxt  = w_load ? r_acc : r_snap;
        w_valid_nxt = w_load | (r_valid & ~snap_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 3'd7;
            r_mask  <= 5'd0;
            r_acc   <= 5'd0;
            r_cnt   <= 4'd0;
            r_snap  <= 5'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_mask  <= w_mask_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_snap  <= w_snap_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign sel        = r_sel;
    assign busy       = r_state != IDLE;
    assign snap       = r_snap;
    assign snap_valid = r_valid;
endmodule

// File: tb/tb_mux_5_1_scanner.sv
// tb_mux_5_1_scanner: two scanners (settle 1 and 3) against a timeline model plus literal expectations
module tb_mux_5_1_scanner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [2];
    logic       ready [2];
    logic [4:0] mask  [2];
    logic [4:0] iv    [2];
    logic [2:0] sel   [2];
    logic       busy  [2];
    logic       vld   [2];
    logic       y     [2];
    logic [4:0] snap  [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_5_1_scanner #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .en_mask(mask[0]), .sel(sel[0]), .mux_y(y[0]),
        .busy(busy[0]), .snap(snap[0]), .snap_valid(vld[0]), .snap_ready(ready[0]));
    mux_5_1_scanner #(.SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .en_mask(mask[1]), .sel(sel[1]), .mux_y(y[1]),
        .busy(busy[1]), .snap(snap[1]), .snap_valid(vld[1]), .snap_ready(ready[1]));

    assign y[0] = (sel[0] < 3'd5) ? iv[0][sel[0]] : 1'b0;
    assign y[1] = (sel[1] < 3'd5) ? iv[1][sel[1]] : 1'b0;

    function automatic int ss(int i);
        return i == 0 ? 1 : 3;
    endfunction

    // Model: t counts edges since start; channel j (1-based) is sampled at edge j*S, publish follows
    logic       m_busy [2];
    logic       m_valid[2];
    logic [2:0] m_sel  [2];
    logic [4:0] m_snap [2];
    logic [4:0] m_acc  [2];
    int         m_t    [2];
    int         m_n    [2];
    int         m_ch   [2][5];

    always @(posedge clk or negedge rst_n) begin
        int t, n, f;
        logic [4:0] acc;
        bit load;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0; m_valid[i] <= 1'b0; m_sel[i] <= 3'd7;
                m_snap[i] <= 5'd0; m_acc[i] <= 5'd0; m_t[i] <= 0; m_n[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                t = m_t[i] + 1;
                acc = m_acc[i];
                load = 1'b0;
                if (!m_busy[i]) begin
                    if (start[i] && mask[i] != 5'd0) begin
                        n = 0;
                        f = 0;
                        for (int k = 0; k < 5; k++) if (mask[i][k]) begin
                            if (n == 0) f = k;
                            m_ch[i][n] <= k;
                            n++;
                        end
                        m_n[i] <= n; m_t[i] <= 0; m_acc[i] <= 5'd0; m_busy[i] <= 1'b1;
                        m_sel[i] <= 3'(f);
                    end
                end else begin
                    if (t <= m_n[i] * ss(i)) begin
                        if (t % ss(i) == 0) acc[m_ch[i][t / ss(i) - 1]] = iv[i][m_ch[i][t / ss(i) - 1]];
                        m_sel[i] <= (t < m_n[i] * ss(i)) ? 3'(m_ch[i][t / ss(i)]) : 3'd7;
                    end else if (!m_valid[i] || ready[i]) begin
                        load = 1'b1;
                        m_busy[i] <= 1'b0;
                    end
                    m_t[i] <= t;
                    m_acc[i] <= acc;
                end
                if (load) begin
                    m_snap[i] <= acc;
                    m_valid[i] <= 1'b1;
                end else if (m_valid[i] && ready[i]) m_valid[i] <= 1'b0;
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d sel", i), int'(sel[i]), int'(m_sel[i]));
                chk($sformatf("u%0d busy", i), int'(busy[i]), int'(m_busy[i]));
                chk($sformatf("u%0d valid", i), int'(vld[i]), int'(m_valid[i]));
                chk($sformatf("u%0d snap", i), int'(snap[i]), int'(m_snap[i]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_scan(int i, logic [4:0] m);
        mask[i] = m;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    // s packs the expected sel values one nibble each, first value in the low nibble
    task automatic sel_seq(int i, string nm, int n, logic [31:0] s);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s sel%0d", nm, k), int'(sel[i]), int'(s[4*k +: 3]));
            chk($sformatf("%s busy%0d", nm, k), int'(busy[i]), 1);
            tick();
        end
    endtask

    task automatic chk_done(int i, string nm, logic [4:0] exp);
        chk({nm, " valid"}, int'(vld[i]), 1);
        chk({nm, " snap"}, int'(snap[i]), int'(exp));
        chk({nm, " idle"}, int'(busy[i]), 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; ready[i] = 1'b1; mask[i] = 5'd0; iv[i] = 5'd0;
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("reset sel", int'(sel[0]), 7);
        chk("reset busy", int'(busy[0]), 0);
        chk("reset snap", int'(snap[0]), 0);
        chk("reset valid", int'(vld[0]), 0);

        iv[0] = 5'b10110;
        start_scan(0, 5'b11111);
        sel_seq(0, "full", 6, 32'h0074_3210);
        chk_done(0, "full", 5'b10110);
        tick();
        chk("full clear", int'(vld[0]), 0);

        start_scan(0, 5'b10101);
        sel_seq(0, "sparse", 4, 32'h0000_7420);
        chk_done(0, "sparse", 5'b10100);
        tick();

        mask[0] = 5'b00000;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("zero mask busy", int'(busy[0]), 0);
        chk("zero mask sel", int'(sel[0]), 7);

        start_scan(0, 5'b00110);
        start[0] = 1'b1;
        mask[0] = 5'b11111;
        sel_seq(0, "ignore", 3, 32'h0000_0721);
        start[0] = 1'b0;
        chk_done(0, "ignore", 5'b00110);
        tick();

        iv[1] = 5'b00001;
        start_scan(1, 5'b00011);
        sel_seq(1, "settle", 4, 32'h0000_1000);
        iv[1] = 5'b00011;
        sel_seq(1, "settle2", 3, 32'h0000_0711);
        chk_done(1, "settle", 5'b00011);
        tick();

        ready[0] = 1'b0;
        iv[0] = 5'b10110;
        start_scan(0, 5'b11111);
        repeat (6) tick();
        chk_done(0, "bp first", 5'b10110);
        iv[0] = 5'b01001;
        start_scan(0, 5'b11111);
        repeat (8) tick();
        chk("bp hold busy", int'(busy[0]), 1);
        chk("bp hold sel", int'(sel[0]), 7);
        chk("bp hold valid", int'(vld[0]), 1);
        chk("bp hold snap", int'(snap[0]), 5'b10110);
        ready[0] = 1'b1;
        tick();
        chk_done(0, "bp second", 5'b01001);
        tick();
        chk("bp drain", int'(vld[0]), 0);

        iv[0] = 5'b10110;
        start_scan(0, 5'b11111);
        repeat (2) tick();
        chk("rst pre sel", int'(sel[0]), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst sel", int'(sel[0]), 7);
        chk("rst busy", int'(busy[0]), 0);
        chk("rst snap", int'(snap[0]), 0);
        chk("rst valid", int'(vld[0]), 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        start_scan(0, 5'b01011);
        sel_seq(0, "post rst", 4, 32'h0000_7310);
        chk_done(0, "post rst", 5'b00010);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_5_1_scanner.md
# mux_5_1_scanner

Sequencer that sits directly upstream of the 5:1 mux and drives its select input. On a start request it steps the mux select through a masked set of channels, waits a programmable settle time on each, samples the mux output, and assembles the samples into a 5-bit snapshot. The snapshot is delivered on a valid/ready handshake to downstream logic, which can apply backpressure.

## Interface
- SETTLE_CYCLES, default 1: cycles `sel` is held per channel before `mux_y` is sampled. Legal range 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  scan request, sampled in IDLE only.
- en_mask  input  5  channel enable; bit k enables channel k. Latched when `start` is accepted.
- sel  output  3  mux select; drives the mux `S` input.
- mux_y  input  1  mux output `Y`, fed back from the mux.
- busy  output  1  high while a scan or publish is in progress (state ≠ IDLE).
- snap  output  5  snapshot; bit k holds the sample of channel k, and bits for disabled channels read 0.
- snap_valid  output  1  snapshot valid.
- snap_ready  input  1  downstream accepts the snapshot.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - `sel`=3'd7 (parked; the mux outputs 0).
  - `busy`=0, `snap`=0, `snap_valid`=0.
  - State=IDLE, internal accumulator=0, latched mask=0, settle counter=0.
- States: IDLE, SETTLE, PUBLISH.
- IDLE:
  - `sel`=7.
  - `start`=1 with `en_mask`≠0: latch the mask, clear the accumulator, set channel to the lowest set mask bit, drive `sel` to that channel, load counter=SETTLE_CYCLES, go to SETTLE.
  - `start`=1 with `en_mask`=0: ignored; stay in IDLE.
- SETTLE:
  - The counter decrements each cycle.
  - On the cycle the counter equals 1, `mux_y` is written into accumulator bit [channel] at that edge.
  - Then, if a higher set bit exists in the latched mask, move `sel` to that channel and reload the counter; otherwise go to PUBLISH.
  - Channels are always visited in ascending order. Channels 5..7 are never driven during a scan.
- PUBLISH:
  - If `snap_valid`=0 or `snap_ready`=1: load `snap` from the accumulator, set `snap_valid`=1, set `sel`=7, go to IDLE.
  - Otherwise hold in PUBLISH (`busy`=1, `sel`=7) until the slot frees. No snapshot is ever dropped or overwritten.
- Handshake:
  - Transfer occurs when `snap_valid`&&`snap_ready` at an edge.
  - On transfer, `snap_valid` clears unless a new snapshot loads on the same edge, in which case it stays 1 with the new data.
  - `snap` is stable while `snap_valid`=1 and not accepted.
- `start` during SETTLE or PUBLISH: ignored, not queued.
- `en_mask` changes during a scan: no effect; the latched copy is used.
- A new scan may start while an older snapshot is still pending. Its PUBLISH waits as described above.
- Reset asserted mid-scan: all outputs return to their reset values immediately (asynchronous); any partial accumulator contents are discarded.

## Timing
- Let edge 0 be the edge that accepts `start`, and N the popcount of the mask.
- `sel` shows the first channel after edge 0.
- Channel j (j=1..N, in scan order) is sampled at edge j·SETTLE_CYCLES. `sel` changes to the next channel after that same edge.
- PUBLISH is entered after edge N·SETTLE_CYCLES.
- With a free slot, `snap_valid` rises after edge N·SETTLE_CYCLES+1, and `busy` falls at the same edge.
- Minimum scan is 2 cycles from start to valid (N=1, SETTLE_CYCLES=1). Maximum is 5·15+1=76 cycles.
- `sel` is registered; there are no combinational paths from inputs to outputs.
- `mux_y` must be valid SETTLE_CYCLES cycles after `sel` changes. The mux is combinational, so SETTLE_CYCLES=1 meets this.

## Test plan
- Full scan, SETTLE_CYCLES=1, `en_mask`=5'b11111, mux I=5'b10110, `snap_ready`=1:
  - `sel` = 0,1,2,3,4 on consecutive cycles, then 7.
  - `snap`=5'b10110 with `snap_valid` high 6 edges after start; `busy` high for 6 cycles.
- Sparse mask, `en_mask`=5'b10101, I=5'b10110:
  - `sel` visits only 0,2,4.
  - `snap`=5'b10100; valid 4 edges after start.
- Settle time, SETTLE_CYCLES=3, `en_mask`=5'b00011, I=5'b00001, with I toggled to 5'b00011 one cycle after `sel`=1:
  - `sel` holds each value for 3 cycles.
  - `snap`=5'b00011, proving the sample is taken on the last settle cycle; valid at edge 7.
- Backpressure:
  - `snap_ready`=0 with a first snapshot pending; start a second scan with I changed to 5'b01001.
  - The scanner holds in PUBLISH with `busy`=1 and the first `snap` stable.
  - Raising `snap_ready` for one cycle transfers the first snapshot and loads 5'b01001 on the same edge; `snap_valid` stays 1.
- Ignored requests:
  - `start` with `en_mask`=0: `busy` stays 0.
  - `start` pulses and `en_mask` changes mid-scan: no effect on `sel` sequence or result.
- Reset mid-scan:
  - Drop `rst_n` while `sel`=2: `sel`=7, `busy`=0, `snap`=0 and `snap_valid`=0 immediately.
  - After release, a fresh scan completes normally with correct data.
